// File: rtl/payload_pkg.sv
// Shared types and defaults for the payload match collector.
package payload_pkg;

  localparam int NUM_ENGINES_DEF = 64;
  localparam int ID_W_DEF = $clog2(NUM_ENGINES_DEF);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SETTLE,
    REPORT
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/payload_prio_enc.sv
// Combinational find-first-set over the engine vector.
module payload_prio_enc
  import payload_pkg::*;
#(
  parameter int NUM_ENGINES = NUM_ENGINES_DEF,
  parameter int ID_W = $clog2(NUM_ENGINES)
) (
  input  logic [NUM_ENGINES-1:0] vec,
  output logic [ID_W-1:0]        index,
  output logic                   any,
  output logic                   single
);

  // Scan downward so the lowest set bit wins.
  always_comb begin
    index = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (vec[i]) index = ID_W'(i);
    end
  end

  assign any = |vec;
  assign single = any && ((vec & (vec - NUM_ENGINES'(1))) == '0);

endmodule

// File: rtl/payload_match_collector.sv
// Snapshots engine match bits at end of payload and streams rule ids.
// Optional popcount output enabled by PAYLOAD_MATCH_COUNT_EN.
module payload_match_collector
  import payload_pkg::*;
#(
  parameter int NUM_ENGINES = NUM_ENGINES_DEF,
  parameter int ID_W = $clog2(NUM_ENGINES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sod,
  input  logic                   en,
  input  logic                   eod,
  input  logic [NUM_ENGINES-1:0] match_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ID_W-1:0]        out_id,
  output logic                   out_none,
  output logic                   out_last,
  output logic                   busy,
  output logic                   sod_err
`ifdef PAYLOAD_MATCH_COUNT_EN
  ,
  output logic [cnt_w(NUM_ENGINES)-1:0] match_cnt
`endif
);

  state_t state;

  logic [NUM_ENGINES-1:0] snap;
  logic [NUM_ENGINES-1:0] snap_clr;
  logic [NUM_ENGINES-1:0] enc_vec;
  logic [ID_W-1:0]        enc_idx;
  logic                   enc_any;
  logic                   enc_single;
  logic                   accept;

  assign accept = out_valid & out_ready;

  // The encoder looks ahead at the vector the next beat will come from.
  always_comb begin
    snap_clr = snap;
    snap_clr[out_id] = 1'b0;
    enc_vec = (state == SETTLE) ? match_in : snap_clr;
  end

  payload_prio_enc #(
    .NUM_ENGINES (NUM_ENGINES),
    .ID_W        (ID_W)
  ) u_enc (
    .vec    (enc_vec),
    .index  (enc_idx),
    .any    (enc_any),
    .single (enc_single)
  );

`ifdef PAYLOAD_MATCH_COUNT_EN
  localparam int CW = cnt_w(NUM_ENGINES);

  logic [CW-1:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      pop = pop + CW'(match_in[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (state == SETTLE) begin
      match_cnt <= pop;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      snap      <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_none  <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      sod_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sod) state <= COLLECT;
        end
        COLLECT: begin
          if (sod) begin
            state <= COLLECT;
          end else if (en && eod) begin
            state <= SETTLE;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          snap      <= match_in;
          out_valid <= 1'b1;
          out_id    <= enc_idx;
          out_none  <= ~enc_any;
          out_last  <= enc_single | ~enc_any;
          state     <= REPORT;
        end
        REPORT: begin
          if (accept) begin
            snap <= snap_clr;
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_id    <= '0;
              out_none  <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              out_id   <= enc_idx;
              out_none <= 1'b0;
              out_last <= enc_single;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (sod && busy) sod_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_payload_match_collector.sv
// Directed scoreboard bench for payload_match_collector.
module tb_payload_match_collector;
  import payload_pkg::*;

  localparam int N = 64;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          sod;
  logic          en;
  logic          eod;
  logic [N-1:0]  match_in;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_id;
  logic          out_none;
  logic          out_last;
  logic          busy;
  logic          sod_err;
`ifdef PAYLOAD_MATCH_COUNT_EN
  logic [6:0]    match_cnt;
`endif

  payload_match_collector #(
    .NUM_ENGINES (N),
    .ID_W        (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sod       (sod),
    .en        (en),
    .eod       (eod),
    .match_in  (match_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_none  (out_none),
    .out_last  (out_last),
    .busy      (busy),
    .sod_err   (sod_err)
`ifdef PAYLOAD_MATCH_COUNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          none;
    logic          last;
  } beat_t;

  beat_t sb[$];
  int    total = 0;
  int    passed = 0;
  int    fails = 0;
  int    exp_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_snap(input logic [N-1:0] s);
    int hi;
    beat_t b;
    exp_cnt = $countones(s);
    if (s == '0) begin
      b.id = '0; b.none = 1'b1; b.last = 1'b1;
      sb.push_back(b);
    end else begin
      hi = 0;
      for (int i = 0; i < N; i++) if (s[i]) hi = i;
      for (int i = 0; i < N; i++) begin
        if (s[i]) begin
          b.id = IW'(i); b.none = 1'b0; b.last = (i == hi);
          sb.push_back(b);
        end
      end
    end
  endtask

  // Ends at the negedge of the SETTLE cycle.
  task automatic send(input int nbytes, input logic [N-1:0] m,
                      input int from);
    @(negedge clk);
    sod = 1'b1; en = 1'b0; eod = 1'b0; match_in = '0;
    @(negedge clk);
    sod = 1'b0;
    for (int b = 1; b <= nbytes; b++) begin
      en = 1'b1;
      eod = (b == nbytes);
      if (b >= from) match_in = m;
      @(negedge clk);
    end
    en = 1'b0;
    eod = 1'b0;
  endtask

  task automatic drain(input bit toggle, input int limit);
    beat_t prev;
    beat_t e;
    bit stalled;
    bit done;
    stalled = 1'b0;
    done = 1'b0;
    prev = '0;
    for (int k = 0; k < limit && !done; k++) begin
      if (k > 0) @(negedge clk);
      out_ready = toggle ? k[0] : 1'b1;
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_id", out_id, prev.id);
        chk("hold_none", out_none, prev.none);
        chk("hold_last", out_last, prev.last);
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            chk("extra_beat", out_valid, 0);
            done = 1'b1;
          end else begin
            e = sb.pop_front();
            chk("beat_id", out_id, e.id);
            chk("beat_none", out_none, e.none);
            chk("beat_last", out_last, e.last);
`ifdef PAYLOAD_MATCH_COUNT_EN
            chk("match_cnt", match_cnt, exp_cnt);
`endif
            if (sb.size() == 0) done = 1'b1;
          end
        end else begin
          stalled = 1'b1;
          prev.id = out_id; prev.none = out_none; prev.last = out_last;
        end
      end
    end
    if (!done) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end else begin
      @(negedge clk);
      chk("valid_after", out_valid, 0);
      chk("busy_after", busy, 0);
    end
  endtask

  task automatic run(input int nbytes, input logic [N-1:0] m,
                     input int from, input bit toggle);
    push_snap(m);
    send(nbytes, m, from);
    chk("settle_valid", out_valid, 0);
    chk("settle_busy", busy, 1);
    @(negedge clk);
    chk("first_valid", out_valid, 1);
    drain(toggle, 4 * N + 20);
  endtask

  logic [N-1:0] v;

  initial begin
    rst = 1'b1; sod = 1'b0; en = 1'b0; eod = 1'b0;
    match_in = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_id", out_id, 0);
    chk("rst_none", out_none, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sod_err", sod_err, 0);
`ifdef PAYLOAD_MATCH_COUNT_EN
    chk("rst_cnt", match_cnt, 0);
`endif
    rst = 1'b0;
    out_ready = 1'b1;

    // Single match from byte 5
    v = '0; v[5] = 1'b1;
    run(10, v, 5, 1'b0);

    // Multi match with backpressure
    v = '0; v[3] = 1'b1; v[17] = 1'b1; v[63] = 1'b1;
    run(6, v, 2, 1'b1);

    // No match
    run(4, '0, 1, 1'b0);

    // Settle timing: bit 9 in SETTLE counts, bit 10 one cycle later does not
    v = '0; v[9] = 1'b1;
    push_snap(v);
    send(5, '0, 1);
    match_in = v;
    @(negedge clk);
    match_in[10] = 1'b1;
    chk("settle_first_valid", out_valid, 1);
    drain(1'b0, 20);

    // All-ones snapshot
    run(3, '1, 1, 1'b0);

    // sod during REPORT
    v = '0; v[1] = 1'b1; v[2] = 1'b1;
    send(4, v, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("sodr_beat1_id", out_id, 1);
    chk("sodr_beat1_last", out_last, 0);
    @(negedge clk);
    out_ready = 1'b0;
    sod = 1'b1;
    chk("sodr_beat2_id", out_id, 2);
    chk("sodr_beat2_last", out_last, 1);
    @(negedge clk);
    sod = 1'b0;
    chk("sodr_hold_valid", out_valid, 1);
    chk("sodr_hold_id", out_id, 2);
    chk("sodr_err", sod_err, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("sodr_done_valid", out_valid, 0);
    chk("sodr_done_busy", busy, 0);

    // eod in IDLE without sod is ignored
    en = 1'b1; eod = 1'b1; match_in = '1;
    @(negedge clk);
    en = 1'b0; eod = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_eod_busy", busy, 0);
    chk("stray_eod_valid", out_valid, 0);
    chk("sod_err_sticky", sod_err, 1);

    // rst mid-REPORT with 40 bits set
    v = '0;
    for (int i = 0; i < 40; i++) v[i] = 1'b1;
    send(3, v, 1);
    out_ready = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      chk("rst_mid_id", out_id, j);
      if (j < 4) @(negedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_sod_err", sod_err, 0);
    out_ready = 1'b1;
    v = '0; v[7] = 1'b1;
    run(10, v, 3, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
